// File: rtl/sdf_twiddle_mult_if.sv
// sdf_twiddle_mult_if: sample stream between an SDF BFII stage, the twiddle multiplier and the next BFI stage.
//   en            pipeline enable (0 = everything holds)
//   in_val        input sample valid
//   frame_start   with in_val: sample is index 0 of a new frame
//   in_re/in_im   input sample (signed)
//   out_val       output sample valid
//   out_re/out_im twiddled output sample (signed)
//   master: producer/consumer side (drives inputs); slave: the multiplier.
interface sdf_twiddle_mult_if #(parameter int DATA_WIDTH = 16);
  logic en, in_val, frame_start, out_val;
  logic signed [DATA_WIDTH-1:0] in_re, in_im, out_re, out_im;
  modport master(output en, in_val, frame_start, in_re, in_im, input out_val, out_re, out_im);
  modport slave(input en, in_val, frame_start, in_re, in_im, output out_val, out_re, out_im);
endinterface

// File: rtl/sdf_twiddle_mult.sv
// sdf_twiddle_mult: multiplies each valid sample by W_Np^k between radix-2^2 SDF stages STAGE and STAGE+1.
//   clk  clock
//   rst  asynchronous active-low reset
//   io   sdf_twiddle_mult_if.slave (en, in_val, frame_start, in_re, in_im -> out_val, out_re, out_im)
// Latency is 3 enabled edges from acceptance. k==0 samples bypass the multiplier untouched.
// Build option: define TW_SATURATE_EN to clamp products to the DATA_WIDTH range instead of wrapping.
module sdf_twiddle_mult #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int N_POINTS   = 16,
  parameter int STAGE      = 0
) (
  input logic clk,
  input logic rst,
  sdf_twiddle_mult_if.slave io
);
  localparam int NP   = N_POINTS >> (2 * STAGE);
  localparam int NW   = $clog2(NP);
  localparam int FRAC = TW_WIDTH - 2;
  localparam int PW   = DATA_WIDTH + TW_WIDTH;
  localparam int SW   = PW + 1;
  typedef logic [NP-1:0][2*TW_WIDTH-1:0] rom_t;
  // {cos, -sin} in Q2.FRAC, rounded half away from zero; only k in 0..3Q-3 is ever addressed.
  function automatic rom_t init_rom();
    rom_t r;
    real a, c, s;
    r = '0;
    for (int k = 0; k <= 3 * (NP / 4) - 3; k++) begin
      a = 2.0 * 3.14159265358979323846 * k / NP;
      c = $cos(a) * (2.0 ** FRAC);
      s = -$sin(a) * (2.0 ** FRAC);
      r[k] = {TW_WIDTH'($rtoi(c < 0.0 ? c - 0.5 : c + 0.5)), TW_WIDTH'($rtoi(s < 0.0 ? s - 0.5 : s + 0.5))};
    end
    return r;
  endfunction
  localparam rom_t ROM = init_rom();
  // Round half up, drop the twiddle fraction, then fit into DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] scale(input logic signed [SW-1:0] x);
`ifdef TW_SATURATE_EN
    logic signed [SW-1:0] r, max_v, min_v;
    max_v = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    min_v = ~max_v;
    r = (x + SW'(1 << (FRAC - 1))) >>> FRAC;
    return r > max_v ? max_v[DATA_WIDTH-1:0] : r < min_v ? min_v[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
`else
    logic signed [SW-1:0] r;
    r = (x + SW'(1 << (FRAC - 1))) >>> FRAC;
    return r[DATA_WIDTH-1:0];
`endif
  endfunction
  logic [NW-1:0] n_q, n_d, n_cur, m, br, k, k1_q, k1_d;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, byp2_q, byp2_d, byp3_q, byp3_d, out_val_q, out_val_d;
  logic signed [DATA_WIDTH-1:0] re1_q, re1_d, im1_q, im1_d, re2_q, re2_d, im2_q, im2_d;
  logic signed [DATA_WIDTH-1:0] re3_q, re3_d, im3_q, im3_d, out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [TW_WIDTH-1:0] twc2_q, twc2_d, tws2_q, tws2_d;
  logic signed [PW-1:0] ac3_q, ac3_d, bd3_q, bd3_d, ad3_q, ad3_d, bc3_q, bc3_d;
  always_comb begin
    n_cur = io.frame_start ? '0 : n_q;
    n_d = !(io.en & io.in_val) ? n_q : io.frame_start ? NW'(1) : n_q == NW'(NP - 1) ? '0 : n_q + NW'(1);
    // n = g*Q + m with Q a power of two; br(g) is g with its two bits swapped.
    m = {2'b00, n_cur[NW-3:0]};
    br = {{(NW-2){1'b0}}, n_cur[NW-2], n_cur[NW-1]};
    k = m * br;
    v1_d = io.in_val;
    re1_d = io.in_re;
    im1_d = io.in_im;
    k1_d = k;
    v2_d = v1_q;
    byp2_d = k1_q == '0;
    re2_d = re1_q;
    im2_d = im1_q;
    {twc2_d, tws2_d} = ROM[k1_q];
    v3_d = v2_q;
    byp3_d = byp2_q;
    re3_d = re2_q;
    im3_d = im2_q;
    ac3_d = PW'(re2_q) * PW'(twc2_q);
    bd3_d = PW'(im2_q) * PW'(tws2_q);
    ad3_d = PW'(re2_q) * PW'(tws2_q);
    bc3_d = PW'(im2_q) * PW'(twc2_q);
    out_val_d = v3_q;
    out_re_d = byp3_q ? re3_q : scale(SW'(ac3_q) - SW'(bd3_q));
    out_im_d = byp3_q ? im3_q : scale(SW'(ad3_q) + SW'(bc3_q));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      n_q <= '0; k1_q <= '0;
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; byp2_q <= 1'b0; byp3_q <= 1'b0; out_val_q <= 1'b0;
      re1_q <= '0; im1_q <= '0; re2_q <= '0; im2_q <= '0; re3_q <= '0; im3_q <= '0;
      twc2_q <= '0; tws2_q <= '0; ac3_q <= '0; bd3_q <= '0; ad3_q <= '0; bc3_q <= '0;
      out_re_q <= '0; out_im_q <= '0;
    end else if (io.en) begin
      n_q <= n_d; k1_q <= k1_d;
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; byp2_q <= byp2_d; byp3_q <= byp3_d; out_val_q <= out_val_d;
      re1_q <= re1_d; im1_q <= im1_d; re2_q <= re2_d; im2_q <= im2_d; re3_q <= re3_d; im3_q <= im3_d;
      twc2_q <= twc2_d; tws2_q <= tws2_d; ac3_q <= ac3_d; bd3_q <= bd3_d; ad3_q <= ad3_d; bc3_q <= bc3_d;
      out_re_q <= out_re_d; out_im_q <= out_im_d;
    end
  assign io.out_val = out_val_q;
  assign io.out_re = out_re_q;
  assign io.out_im = out_im_q;
endmodule

// File: tb/tb_sdf_twiddle_mult.sv
// tb_sdf_twiddle_mult: randomized and directed checks of sdf_twiddle_mult against a plain-arithmetic model.
module tb_sdf_twiddle_mult;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  sdf_twiddle_mult_if #(.DATA_WIDTH(16)) io();
  sdf_twiddle_mult #(.DATA_WIDTH(16), .TW_WIDTH(16), .N_POINTS(16), .STAGE(0)) dut (.clk(clk), .rst(rst), .io(io));
  typedef struct {bit v; int re, im; bit hc; int cre, cim;} ent_t;
  ent_t pipe [4];
  int n_m = 0;
  int checks = 0, failures = 0;
`ifdef TW_SATURATE_EN
  localparam int OVF_RE = 32767;
`else
  localparam int OVF_RE = -19197;
`endif
  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int rnd(input real x);
    return $rtoi(x < 0.0 ? x - 0.5 : x + 0.5);
  endfunction
  function automatic int fit(input longint x);
`ifdef TW_SATURATE_EN
    return x > 32767 ? 32767 : x < -32768 ? -32768 : int'(x);
`else
    return int'(16'(x));
`endif
  endfunction
  // Reference: W_16^k with k = (n mod 4) * br(n / 4), applied with exact integer arithmetic.
  function automatic void model(input int n, input int a, input int b, output int er, output int ei);
    int br_t [4] = '{0, 2, 1, 3};
    int k, c, d;
    k = (n % 4) * br_t[n / 4];
    if (k == 0) begin
      er = a;
      ei = b;
      return;
    end
    c = rnd($cos(2.0 * 3.14159265358979323846 * k / 16.0) * 16384.0);
    d = rnd(-$sin(2.0 * 3.14159265358979323846 * k / 16.0) * 16384.0);
    er = fit((longint'(a) * c - longint'(b) * d + 8192) >>> 14);
    ei = fit((longint'(a) * d + longint'(b) * c + 8192) >>> 14);
  endfunction
  task automatic clear_model();
    for (int i = 0; i < 4; i++) pipe[i] = '{default: 0};
    n_m = 0;
  endtask
  task automatic step(input bit en, input bit val, input bit fs, input int re, input int im,
                      input bit hc = 1'b0, input int cre = 0, input int cim = 0);
    ent_t e;
    int n;
    io.en = en; io.in_val = val; io.frame_start = fs; io.in_re = 16'(re); io.in_im = 16'(im);
    @(posedge clk);
    if (en) begin
      e = '{default: 0};
      e.v = val;
      if (val) begin
        n = fs ? 0 : n_m;
        n_m = (n + 1) % 16;
        model(n, re, im, e.re, e.im);
        e.hc = hc; e.cre = cre; e.cim = cim;
      end
      for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = e;
    end
    #1;
    check("out_val", io.out_val, pipe[3].v);
    if (pipe[3].v) begin
      check("out_re", io.out_re, pipe[3].re);
      check("out_im", io.out_im, pipe[3].im);
      if (pipe[3].hc) begin
        check("known_re", io.out_re, pipe[3].cre);
        check("known_im", io.out_im, pipe[3].cim);
      end
    end
    @(negedge clk);
  endtask
  task automatic flush();
    repeat (4) step(1, 0, 0, 0, 0);
  endtask
  function automatic int rdat();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction
  initial begin
    io.en = 1'b0; io.in_val = 1'b0; io.frame_start = 1'b0; io.in_re = '0; io.in_im = '0;
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_val", io.out_val, 0);
    check("rst_re", io.out_re, 0);
    check("rst_im", io.out_im, 0);
    rst = 1'b1;
    for (int n = 0; n < 16; n++)
      step(1, 1, n == 0, 1000, 0, n <= 5 || n == 8 || n == 13,
           n == 5 ? 707 : n == 13 ? 383 : 1000, n == 5 ? -707 : n == 13 ? -924 : 0);
    flush();
    step(1, 1, 1, rdat(), rdat());
    for (int n = 1; n < 4; n++) step(1, 1, 0, rdat(), rdat());
    flush();
    step(1, 1, 0, 1234, -4321);
    repeat (5) step(1, 0, 0, 0, 0);
    step(1, 1, 1, rdat(), rdat());
    for (int n = 1; n < 6; n++) step(1, 1, 0, rdat(), rdat());
    repeat (5) step(0, $urandom_range(0, 1), 0, rdat(), rdat());
    for (int n = 6; n < 12; n++) step(1, 1, 0, rdat(), rdat());
    flush();
    step(1, 1, 1, rdat(), rdat());
    for (int n = 1; n < 7; n++) step(1, 1, 0, rdat(), rdat());
    step(1, 1, 1, 1000, 500, 1, 1000, 500);
    for (int n = 1; n < 5; n++) step(1, 1, 0, rdat(), rdat());
    flush();
    step(1, 1, 1, 0, 0);
    for (int n = 1; n < 5; n++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 32767, 32767, 1, OVF_RE, 0);
    flush();
    for (int n = 0; n < 6; n++) step(1, 1, n == 0, 2000 + n, -3000);
    #2 rst = 1'b0;
    #1;
    check("async_rst_val", io.out_val, 0);
    check("async_rst_re", io.out_re, 0);
    check("async_rst_im", io.out_im, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 20; n++) step(1, 1, 0, rdat(), rdat());
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0, rdat(), rdat());
    flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
